// File: rtl/move_input_sequencer.sv
// Connect-4 input stage: synchronises and debounces the column switches and
// drop button, validates the requested column against local fill heights and
// issues one move per accepted press on a valid/ready handshake.
module move_input_sequencer #(
  parameter int COLS            = 4,
  parameter int ROWS            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] switches,
  input  logic            btn_east,
  input  logic            game_active,
  input  logic            clear_board,
  input  logic            move_ready,
  output logic            move_valid,
  output logic [1:0]      move_col,
  output logic [2:0]      move_row,
  output logic            move_reject,
  output logic            board_full,
  output logic            busy
);

  localparam int HW = 3;
  localparam int OW = $clog2(COLS + 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic              btn_s1_q, btn_s2_q;
  logic [COLS-1:0]   sw_s1_q, sw_s2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stable_q, stable_d;
  logic              stable_prev_q;
  logic [COLS-1:0]   cap_q, cap_d;
  logic [HW-1:0]     height_q [COLS];
  logic [HW-1:0]     height_d [COLS];
  logic              valid_q, valid_d;
  logic [1:0]        col_q, col_d;
  logic [2:0]        row_q, row_d;
  logic              reject_q, reject_d;
  logic              full_q, full_d;

  logic              press;
  logic [OW-1:0]     ones;
  logic [1:0]        enc;
  logic              bad_pick;

  assign press = stable_q & ~stable_prev_q;

  // Two-flop synchronisers for the raw button and switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_east;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= switches;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Debounce: the stable level follows the synced button only after a full run of agreeing cycles.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (btn_s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = btn_s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Captured switch pattern decode: bit count and binary column index.
  always_comb begin
    ones = '0;
    enc  = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (cap_q[i]) begin
        ones = ones + OW'(1);
        enc  = 2'(i);
      end
    end
    bad_pick = (ones != OW'(1)) || (height_q[enc] == HW'(ROWS));
  end

  // State register plus all datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cap_q         <= '0;
      height_q      <= '{default: '0};
      valid_q       <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      reject_q      <= 1'b0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cap_q         <= cap_d;
      height_q      <= height_d;
      valid_q       <= valid_d;
      col_q         <= col_d;
      row_q         <= row_d;
      reject_q      <= reject_d;
      full_q        <= full_d;
    end
  end

  // Next-state logic; clear_board overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear_board) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:         if (press && game_active) state_d = CHECK;
        CHECK:        state_d = bad_pick ? WAIT_RELEASE : ISSUE;
        ISSUE:        if (move_ready) state_d = WAIT_RELEASE;
        WAIT_RELEASE: if (!stable_q) state_d = IDLE;
        default:      state_d = IDLE;
      endcase
    end
  end

  // Output and height updates per state; board_full looks at next heights so it rises right after the final accept.
  always_comb begin
    cap_d    = cap_q;
    height_d = height_q;
    valid_d  = valid_q;
    col_d    = col_q;
    row_d    = row_q;
    reject_d = 1'b0;
    if (clear_board) begin
      height_d = '{default: '0};
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          if (press && game_active) cap_d = sw_s2_q;
        end
        CHECK: begin
          if (bad_pick) begin
            reject_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            col_d   = enc;
            row_d   = height_q[enc];
          end
        end
        ISSUE: begin
          if (move_ready) begin
            valid_d = 1'b0;
            if (height_q[col_q] != HW'(ROWS)) height_d[col_q] = height_q[col_q] + HW'(1);
          end
        end
        default: valid_d = 1'b0;
      endcase
    end
    full_d = 1'b1;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (height_d[c] != HW'(ROWS)) full_d = 1'b0;
    end
  end

  assign move_valid  = valid_q;
  assign move_col    = col_q;
  assign move_row    = row_q;
  assign move_reject = reject_q;
  assign board_full  = full_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_move_input_sequencer.sv
// Directed bench for move_input_sequencer with a scoreboard of expected moves.
module tb_move_input_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] switches;
  logic       btn_east;
  logic       game_active;
  logic       clear_board;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_col;
  logic [2:0] move_row;
  logic       move_reject;
  logic       board_full;
  logic       busy;

  move_input_sequencer #(
    .COLS(4),
    .ROWS(4),
    .DEBOUNCE_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .switches(switches),
    .btn_east(btn_east),
    .game_active(game_active),
    .clear_board(clear_board),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_col(move_col),
    .move_row(move_row),
    .move_reject(move_reject),
    .board_full(board_full),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rej;
    logic [1:0] col;
    logic [2:0] row;
  } exp_t;

  exp_t sb[$];
  int   hgt[4];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [3:0] sw);
    exp_t e;
    e = '0;
    if ($countones(sw) != 1) begin
      e.rej = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (sw[i]) e.col = 2'(i);
      if (hgt[e.col] >= 4) e.rej = 1'b1;
      else e.row = 3'(hgt[e.col]);
    end
    return e;
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < 4; i++) if (hgt[i] != 4) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (move_valid || move_reject) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic release_and_watch();
    int extra;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (move_valid || move_reject) extra++;
    end
    btn_east = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (move_valid || move_reject) extra++;
    end
    chk("no_retrigger", extra, 0);
    chk("idle_after_release", busy, 1'b0);
    move_ready = 1'b1;
  endtask

  task automatic do_press(input logic [3:0] sw, input int delay, input bit bounce, input bit clear_mid);
    exp_t e;
    bit   seen;
    bit   stable_ok;
    @(negedge clk);
    switches   = sw;
    move_ready = (delay == 0) && !clear_mid;
    sb.push_back(predict(sw));
    repeat (3) @(negedge clk);
    if (bounce) begin
      for (int t = 0; t < 5; t++) begin
        btn_east = ~btn_east;
        repeat (2) @(negedge clk);
      end
    end
    btn_east = 1'b1;
    wait_out(seen);
    chk("output_seen", seen, 1'b1);
    e = sb.pop_front();
    if (seen) begin
      chk("reject_flag", move_reject, e.rej);
      chk("valid_reject_exclusive", move_valid & move_reject, 1'b0);
      if (!e.rej) begin
        chk("move_col", move_col, e.col);
        chk("move_row", move_row, e.row);
        if (clear_mid) begin
          clear_board = 1'b1;
          @(negedge clk);
          clear_board = 1'b0;
          for (int i = 0; i < 4; i++) hgt[i] = 0;
          chk("clear_valid", move_valid, 1'b0);
          chk("clear_busy", busy, 1'b0);
          chk("clear_full", board_full, 1'b0);
        end else begin
          if (delay > 0) begin
            stable_ok = 1'b1;
            repeat (delay) begin
              @(negedge clk);
              if (move_valid !== 1'b1 || move_col !== e.col || move_row !== e.row) stable_ok = 1'b0;
            end
            chk("hold_under_backpressure", stable_ok, 1'b1);
            move_ready = 1'b1;
          end
          @(negedge clk);
          hgt[e.col]++;
          chk("valid_drop_after_accept", move_valid, 1'b0);
          chk("board_full", board_full, model_full());
        end
      end else begin
        @(negedge clk);
        chk("reject_one_cycle", move_reject, 1'b0);
        chk("reject_no_valid", move_valid, 1'b0);
      end
    end
    release_and_watch();
  endtask

  initial begin
    exp_t e;
    bit   seen;
    int   cnt;
    reset       = 1'b0;
    switches    = '0;
    btn_east    = 1'b0;
    game_active = 1'b1;
    clear_board = 1'b0;
    move_ready  = 1'b1;
    for (int i = 0; i < 4; i++) hgt[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", move_valid, 1'b0);
    chk("rst_col", move_col, 2'd0);
    chk("rst_row", move_row, 3'd0);
    chk("rst_reject", move_reject, 1'b0);
    chk("rst_full", board_full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic moves on column 2
    do_press(4'b0100, 0, 1'b0, 1'b0);
    do_press(4'b0100, 0, 1'b0, 1'b0);

    // Fill column 0, then one press too many
    repeat (4) do_press(4'b0001, 0, 1'b0, 1'b0);
    do_press(4'b0001, 0, 1'b0, 1'b0);

    // Invalid patterns
    do_press(4'b0101, 0, 1'b0, 1'b0);
    do_press(4'b0000, 0, 1'b0, 1'b0);

    // Short glitch must not register
    @(negedge clk);
    switches = 4'b0010;
    btn_east = 1'b1;
    repeat (10) @(negedge clk);
    btn_east = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (move_valid || move_reject || busy) cnt++;
    end
    chk("glitch_ignored", cnt, 0);

    // Bouncy press then stable hold gives one move
    do_press(4'b0010, 0, 1'b1, 1'b0);

    // Press while inactive, game becomes active while still held
    @(negedge clk);
    game_active = 1'b0;
    switches    = 4'b0010;
    btn_east    = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (move_valid || move_reject || busy) cnt++;
    end
    game_active = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (move_valid || move_reject || busy) cnt++;
    end
    chk("inactive_press_ignored", cnt, 0);
    release_and_watch();

    // Backpressure, then clear during a pending move
    do_press(4'b1000, 20, 1'b0, 1'b0);
    do_press(4'b1000, 0, 1'b0, 1'b1);
    do_press(4'b0100, 0, 1'b0, 1'b0);
    chk("row_after_clear_seen", hgt[2], 1);

    // Clear again and fill the whole board
    @(negedge clk);
    clear_board = 1'b1;
    @(negedge clk);
    clear_board = 1'b0;
    for (int i = 0; i < 4; i++) hgt[i] = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        do_press(4'(1 << c), 0, 1'b0, 1'b0);
      end
    end
    chk("board_full_final", board_full, 1'b1);
    do_press(4'b1000, 0, 1'b0, 1'b0);

    // Clear, then asynchronous reset while a move is pending
    @(negedge clk);
    clear_board = 1'b1;
    @(negedge clk);
    clear_board = 1'b0;
    for (int i = 0; i < 4; i++) hgt[i] = 0;
    chk("full_cleared", board_full, 1'b0);
    do_press(4'b1000, 0, 1'b0, 1'b0);
    @(negedge clk);
    switches   = 4'b1000;
    move_ready = 1'b0;
    sb.push_back(predict(4'b1000));
    repeat (3) @(negedge clk);
    btn_east = 1'b1;
    wait_out(seen);
    chk("reset_case_seen", seen, 1'b1);
    e = sb.pop_front();
    chk("reset_case_row", move_row, e.row);
    reset    = 1'b0;
    btn_east = 1'b0;
    #1;
    chk("async_valid", move_valid, 1'b0);
    chk("async_row", move_row, 3'd0);
    chk("async_busy", busy, 1'b0);
    chk("async_reject", move_reject, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) hgt[i] = 0;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);
    do_press(4'b1000, 0, 1'b0, 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
